// File: rtl/updown_counter_mod.sv
// Modulo-MOD up/down counter with load/clear, wrap-or-saturate boundary and terminal-count flags.
// Latency: q, wrap and ovf update one cycle after the sampled controls; tc and qb are combinational.
// Backpressure: none; every control is sampled on each rising edge (clr > load > en > hold).
module updown_counter_mod #(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    if (WIDTH < 2 || MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_param
        $error("updown_counter_mod: illegal WIDTH/MOD combination");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   nxt_ext;
    logic             at_top, at_bot;

    assign at_top = (count_q == MAX_V);
    assign at_bot = (count_q == '0);

    always_comb begin
        nxt_ext = {1'b0, count_q};
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            nxt_ext = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            nxt_ext = {1'b0, load_val};
        end else if (en) begin
            if (up_down) begin
                if (at_top) begin
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                    if (!SATURATE) nxt_ext = '0;
                end else begin
                    nxt_ext = {1'b0, count_q} + 1'b1;
                end
            end else begin
                if (at_bot) begin
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                    if (!SATURATE) nxt_ext = {1'b0, MAX_V};
                end else begin
                    nxt_ext = {1'b0, count_q} - 1'b1;
                end
            end
        end
        // Single clamp point: covers out-of-range loads and keeps q below MOD.
        count_d = (nxt_ext > {1'b0, MAX_V}) ? MAX_V : nxt_ext[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q    = count_q;
    assign qb   = ~count_q;
    assign tc   = en & (up_down ? at_top : at_bot);
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised synchronous up/down counter with programmable modulus, wrap or saturate mode, synchronous load/clear and terminal-count flags. Replaces the fixed 4-bit ripple up/down counter for all new counting, timing and sequencing uses. Every flop is in the single `clk` domain, and the count advances on the rising edge. The block is the standard counter primitive for timers and prescalers.

## Interface
- WIDTH, 4: counter width in bits; must be ≥ 2.
- MOD, 16: count range is 0..MOD-1; 2 ≤ MOD ≤ 2^WIDTH.
- SATURATE, 0: boundary behaviour. 0 wraps; 1 holds at the end value.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable (toggle enable); the count moves only when en=1.
- up_down  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- clr  input  1  synchronous clear to 0.
- q  output  WIDTH  current count.
- qb  output  WIDTH  bitwise complement of q.
- tc  output  1  terminal count, combinational from q and up_down.
- wrap  output  1  one-cycle pulse after a wrap or saturation hit.
- ovf  output  1  sticky overflow/underflow flag; cleared by clr or reset.

## Operation
- Priority at each rising edge: clr > load > en > hold.
- **clr:**
  - q ← 0, ovf ← 0, wrap ← 0.
- **load:**
  - q ← load_val when load_val ≤ MOD-1; otherwise q ← MOD-1 (clamp).
  - No wrap pulse; ovf is unchanged.
- **en, up_down=1:**
  - q < MOD-1: q ← q+1.
  - q = MOD-1 and SATURATE=0: q ← 0, wrap ← 1, ovf ← 1.
  - q = MOD-1 and SATURATE=1: q holds, wrap ← 1, ovf ← 1.
- **en, up_down=0:**
  - q > 0: q ← q-1.
  - q = 0 and SATURATE=0: q ← MOD-1, wrap ← 1, ovf ← 1.
  - q = 0 and SATURATE=1: q holds, wrap ← 1, ovf ← 1.
- wrap is 0 on every edge that does not take a boundary transition.
- tc = 1 when en=1 and the next enabled edge would take a boundary transition:
  - counting up and q = MOD-1, or
  - counting down and q = 0.
- qb = ~q at all times, including during reset.
- Arithmetic is done in WIDTH+1 bits internally. q must never hold a value ≥ MOD.
- With MOD = 2^WIDTH, wrap is the natural binary roll-over, but all flags still behave as above.
- A direction change takes effect on the next enabled edge. There is no dead cycle.

## Timing
- Reset (rst=0, asynchronous) forces q=0, qb=all ones, wrap=0, ovf=0 immediately, independent of clk.
- Release is synchronous in effect: the first count happens on the first rising edge with rst=1 and en=1.
- Latency: one cycle from an en/load/clr sample to the updated q.
- wrap is registered and is high for exactly the cycle after the boundary edge.
- tc is combinational, valid in the same cycle as q; it has no register delay.
- ovf sets on the boundary edge and stays set until clr=1 or rst=0.
- Reset asserted mid-count overrides everything. No partial update may be visible.
- load and en asserted together: load wins and the count is not incremented.
- clr and load asserted together: clr wins.

## Test plan
- **Reset mid-count.** WIDTH=4, MOD=10. Pulse rst low, release, en=1, up_down=1, 12 edges.
  - Count sequence is 1..9, 0, 1, 2.
  - wrap is high only in the cycle after 9→0.
  - tc is high while q=9.
  - ovf=1 from that point.
- **Down wrap.** MOD=10, SATURATE=0, count from 0 with up_down=0.
  - Sequence is 9, 8, ... with wrap pulsed once.
  - Then drive rst low while q=5: q=0, qb=4'hF, and ovf clears asynchronously.
- **Saturate.** MOD=10, SATURATE=1, up_down=1, 15 enabled edges.
  - q holds at 9 after reaching it.
  - wrap pulses on every enabled edge at 9.
  - ovf=1.
  - Switch to up_down=0: q steps to 8 on the next edge.
- **Load and priority.**
  - load_val=7 with en=1: q=7 with no increment.
  - load_val=13: q=9 (clamped).
  - clr and load together: q=0, ovf=0.
- **Full-range modulus.** WIDTH=4, MOD=16, up_down=1 from 15.
  - q=0, wrap=1, qb=4'hF.
- **Hold and direction toggle.**
  - en=0 for 5 cycles: q, wrap and ovf are unchanged.
  - Toggle up_down every cycle with en=1 from 4: sequence 5, 4, 5, 4.
